// File: rtl/dp_wb_seq.sv
// dp_wb_seq: steps an external group mux through the SMAC result groups and
// streams each selected word onto a registered valid/ready writeback bus.
module dp_wb_seq #(
    parameter int BW   = 128,
    parameter int NGRP = 4,
    localparam int GW  = $clog2(NGRP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [GW-1:0] n_groups,
    input  logic [BW-1:0] in_mux,
    output logic [GW-1:0] act_wb,
    output logic [BW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] act_wb_q, act_wb_d;
    logic [GW-1:0] last_q, last_d;
    logic [BW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          hs;

    assign hs = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            act_wb_q    <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_wb_q    <= act_wb_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = SEND;
            SEND:    state_d = !hs ? SEND : (act_wb_q == last_q) ? DONE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    // The mux word is only captured in LOAD, so in_mux never reaches an output combinationally.
    always_comb begin
        last_d      = (state_q == IDLE && start) ? n_groups : last_q;
        out_data_d  = (state_q == LOAD) ? in_mux : out_data_q;
        out_valid_d = (state_q == LOAD) ? 1'b1 : (state_q == SEND && hs) ? 1'b0 : out_valid_q;
        act_wb_d    = (state_q == SEND && hs && act_wb_q != last_q) ? act_wb_q + 1'b1 :
                      (state_q == DONE) ? '0 : act_wb_q;
        act_wb      = act_wb_q;
        out_data    = out_data_q;
        out_valid   = out_valid_q;
        busy        = state_q != IDLE;
        done        = state_q == DONE;
    end
endmodule

// File: tb/tb_dp_wb_seq.sv
// tb_dp_wb_seq: randomized writeback sequences scored against a per-transfer
// list of expected group words, plus directed latency, stall, start-ignore and reset cases.
module tb_dp_wb_seq;
    localparam int BW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    n_groups;
    logic [BW-1:0] in_mux;
    logic [1:0]    act_wb;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    typedef struct {
        int          c;
        logic [1:0]  g;
        logic [BW-1:0] d;
    } hs_t;

    logic [BW-1:0] grp_data [4];
    hs_t           hs_q [$];
    int            done_q [$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    dp_wb_seq #(.BW(BW), .NGRP(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_groups(n_groups),
        .in_mux(in_mux), .act_wb(act_wb), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Downstream group mux model: combinational select by act_wb.
    assign in_mux = grp_data[act_wb];

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus monitor: records accepted words and done pulses, and checks hold behaviour.
    initial begin
        logic          have_prev;
        logic          prev_valid, prev_ready;
        logic [1:0]    prev_grp;
        logic [BW-1:0] prev_data;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) have_prev = 1'b0;
            else begin
                if (have_prev && prev_valid && !prev_ready) begin
                    chk("stall_data", out_data, prev_data);
                    chk("stall_grp", BW'(act_wb), BW'(prev_grp));
                    chk("stall_vld", BW'(out_valid), 1);
                end else if (have_prev && !out_valid)
                    chk("idle_hold", out_data, prev_data);
                if (out_valid && out_ready) hs_q.push_back('{cyc, act_wb, out_data});
                if (done) done_q.push_back(cyc);
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_grp   = act_wb;
                prev_data  = out_data;
                have_prev  = 1'b1;
            end
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 4; i++) grp_data[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // mode 0: ready high, 1: random ready, 2: 5-cycle stall on first word, 3: stray starts.
    // Called and returns one time unit after a rising edge.
    task automatic run_wb(input int mode, input logic [1:0] n);
        int s, bp, t, last;
        bit inj;
        n_groups  = n;
        start     = 1'b1;
        s         = cyc;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0; bp = 0; inj = 1'b0;
        while (!done && t < 300) begin
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            if (mode == 2) begin
                if (out_valid && bp < 5) begin out_ready = 1'b0; bp++; end
                else out_ready = 1'b1;
            end
            if (mode == 3) begin
                start = out_valid && !inj;
                if (out_valid && !inj) begin n_groups = 2'd0; inj = 1'b1; end
            end
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk("timeout", BW'(t), 0);
        start = (mode == 3);
        @(posedge clk); #1;
        start = 1'b0;
        chk("count", BW'(hs_q.size()), BW'(n) + 1);
        for (int i = 0; i < hs_q.size() && i <= int'(n); i++) begin
            chk("grp", BW'(hs_q[i].g), BW'(i));
            chk("data", hs_q[i].d, grp_data[i]);
            if (mode == 0) chk("lat", BW'(hs_q[i].c), BW'(s + 2 + 2 * i));
        end
        chk("done_n", BW'(done_q.size()), 1);
        if (done_q.size() > 0 && hs_q.size() > 0) begin
            last = hs_q[hs_q.size() - 1].c;
            chk("done_cyc", BW'(done_q[0]), BW'(last + 1));
            if (mode == 0) chk("start_to_done", BW'(done_q[0] - s + 1), BW'(2 * (int'(n) + 1) + 2));
        end
        hs_q.delete();
        done_q.delete();
        repeat (4) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("no_extra", BW'(hs_q.size() + done_q.size()), 0);
        chk("idle_busy", BW'(busy), 0);
        chk("idle_act", BW'(act_wb), 0);
        hs_q.delete();
        done_q.delete();
    endtask

    initial begin
        int t;
        rst_n = 1'b0; start = 1'b0; n_groups = 2'd0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) grp_data[i] = '0;
        #12;
        chk("rst_act", BW'(act_wb), 0);
        chk("rst_data", out_data, 0);
        chk("rst_vld", BW'(out_valid), 0);
        chk("rst_busy", BW'(busy), 0);
        chk("rst_done", BW'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) grp_data[i] = BW'(32'hA0 + i);
        run_wb(0, 2'd3);
        fill_random(); run_wb(0, 2'd0);
        fill_random(); run_wb(2, 2'd1);
        fill_random(); run_wb(3, 2'd3);

        // Abort mid-transfer on group 2, then restart immediately after reset.
        fill_random();
        n_groups = 2'd3; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!(out_valid && act_wb == 2'd2) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("reach_g2", BW'(out_valid && act_wb == 2'd2), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_act", BW'(act_wb), 0);
        chk("arst_data", out_data, 0);
        chk("arst_vld", BW'(out_valid), 0);
        chk("arst_busy", BW'(busy), 0);
        chk("arst_done", BW'(done), 0);
        repeat (2) @(posedge clk);
        chk("arst_nodone", BW'(done_q.size()), 0);
        hs_q.delete();
        done_q.delete();
        #1 rst_n = 1'b1;
        fill_random(); run_wb(0, 2'd2);

        for (int k = 0; k < 100; k++) begin
            fill_random();
            run_wb(1, 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
